// File: rtl/calc_op_sequencer.sv
// calc_op_sequencer: sequences one matrix operation from request through operand
// selection (with bounded retries after selector errors) and compute, reporting
// done / fail / abort to the UI layer.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// IDLE       | waiting for op_req
// SEL_REQ    | sel_start pulse, kicks off operand selection
// SEL_WAIT   | waiting for sel_done or sel_error (no timeout: manual entry)
// ERR_HOLD   | holding ERR_HOLD_CYCLES cycles after a selector error
// SEL_CLR    | sel_start pulse that clears the selector out of its ERROR state
// SEL_GAP    | one idle cycle before the restart pulse
// CALC_REQ   | alu_start pulse with latched op type and operand IDs
// CALC_WAIT  | waiting for alu_done, bounded by CALC_TIMEOUT cycles
// FINISH     | op_done pulse
// FAIL       | op_fail pulse, fail_code already valid
module calc_op_sequencer #(
    parameter int ERR_HOLD_CYCLES = 16,
    parameter int RETRY_MAX       = 2,
    parameter int CALC_TIMEOUT    = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       op_req,
    input  logic [2:0] op_type,
    input  logic       manual_mode,
    input  logic       abort,
    output logic       sel_start,
    output logic       sel_manual,
    output logic [2:0] sel_op_type,
    input  logic       sel_done,
    input  logic       sel_error,
    input  logic [3:0] sel_a,
    input  logic [3:0] sel_b,
    output logic       alu_start,
    output logic [2:0] alu_op,
    output logic [3:0] alu_id_a,
    output logic [3:0] alu_id_b,
    input  logic       alu_done,
    output logic       busy,
    output logic       op_done,
    output logic       op_fail,
    output logic [1:0] fail_code,
    output logic [1:0] retry_cnt
);

    // One down-counter serves both the error hold and the compute timeout;
    // it is sized for the larger of the two.
    localparam int CNT_MAX = (CALC_TIMEOUT > ERR_HOLD_CYCLES) ? CALC_TIMEOUT : ERR_HOLD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // Counters are loaded with N-1 and expire on the cycle they read zero,
    // so the owning state lasts exactly N cycles.
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(ERR_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CALC_LOAD = CNT_W'(CALC_TIMEOUT - 1);
    localparam logic [1:0]       RETRY_LIM = 2'(RETRY_MAX);

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_SEL     = 2'b01;
    localparam logic [1:0] FC_TIMEOUT = 2'b10;
    localparam logic [1:0] FC_ABORT   = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SEL_REQ,
        S_SEL_WAIT,
        S_ERR_HOLD,
        S_SEL_CLR,
        S_SEL_GAP,
        S_CALC_REQ,
        S_CALC_WAIT,
        S_FINISH,
        S_FAIL
    } state_t;

    state_t           state_q, state_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic [1:0]       retry_nxt;
    logic [1:0]       fail_nxt;
    logic             accept;
    logic             latch_ids;
    logic             abort_ok;

    // Next-state, counter and status decisions for the sequencer.
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        retry_nxt = retry_cnt;
        fail_nxt  = fail_code;
        accept    = 1'b0;
        latch_ids = 1'b0;
        abort_ok  = abort && (state_q != S_IDLE) && (state_q != S_FINISH) && (state_q != S_FAIL);

        if (abort_ok) begin
            // Abort outranks any done/error arriving in the same cycle.
            state_nxt = S_FAIL;
            fail_nxt  = FC_ABORT;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (op_req) begin
                        accept    = 1'b1;
                        retry_nxt = 2'd0;
                        fail_nxt  = FC_NONE;
                        state_nxt = S_SEL_REQ;
                    end
                end
                S_SEL_REQ: state_nxt = S_SEL_WAIT;
                S_SEL_WAIT: begin
                    if (sel_done) begin
                        latch_ids = 1'b1;
                        state_nxt = S_CALC_REQ;
                    end else if (sel_error) begin
                        cnt_nxt   = HOLD_LOAD;
                        state_nxt = S_ERR_HOLD;
                    end
                end
                S_ERR_HOLD: begin
                    if (cnt_q == '0) begin
                        if (retry_cnt < RETRY_LIM) begin
                            retry_nxt = retry_cnt + 2'd1;
                            state_nxt = S_SEL_CLR;
                        end else begin
                            fail_nxt  = FC_SEL;
                            state_nxt = S_FAIL;
                        end
                    end else begin
                        cnt_nxt = cnt_q - 1'b1;
                    end
                end
                S_SEL_CLR: state_nxt = S_SEL_GAP;
                S_SEL_GAP: state_nxt = S_SEL_REQ;
                S_CALC_REQ: begin
                    cnt_nxt   = CALC_LOAD;
                    state_nxt = S_CALC_WAIT;
                end
                S_CALC_WAIT: begin
                    if (alu_done) begin
                        state_nxt = S_FINISH;
                    end else if (cnt_q == '0) begin
                        fail_nxt  = FC_TIMEOUT;
                        state_nxt = S_FAIL;
                    end else begin
                        cnt_nxt = cnt_q - 1'b1;
                    end
                end
                S_FINISH: state_nxt = S_IDLE;
                S_FAIL:   state_nxt = S_IDLE;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    // State and shared down-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    // Registered outputs decoded from the next state so pulses line up with their state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_start   <= 1'b0;
            sel_manual  <= 1'b0;
            sel_op_type <= 3'd0;
            alu_start   <= 1'b0;
            alu_op      <= 3'd0;
            alu_id_a    <= 4'd0;
            alu_id_b    <= 4'd0;
            busy        <= 1'b0;
            op_done     <= 1'b0;
            op_fail     <= 1'b0;
            fail_code   <= FC_NONE;
            retry_cnt   <= 2'd0;
        end else begin
            sel_start <= (state_nxt == S_SEL_REQ) || (state_nxt == S_SEL_CLR);
            alu_start <= (state_nxt == S_CALC_REQ);
            busy      <= (state_nxt != S_IDLE);
            op_done   <= (state_nxt == S_FINISH);
            op_fail   <= (state_nxt == S_FAIL);
            fail_code <= fail_nxt;
            retry_cnt <= retry_nxt;
            if (accept) begin
                sel_manual  <= manual_mode;
                sel_op_type <= op_type;
                alu_op      <= op_type;
            end
            if (latch_ids) begin
                alu_id_a <= sel_a;
                alu_id_b <= sel_b;
            end
        end
    end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Directed bench for calc_op_sequencer: nominal flow, retry, retry exhaustion,
// compute timeout and its done-wins boundary, abort/overlap and async reset.
module tb_calc_op_sequencer;

    localparam int ERR_HOLD = 16;
    localparam int T_CALC   = 1024;

    logic       clk;
    logic       rst_n;
    logic       op_req;
    logic [2:0] op_type;
    logic       manual_mode;
    logic       abort;
    logic       sel_start;
    logic       sel_manual;
    logic [2:0] sel_op_type;
    logic       sel_done;
    logic       sel_error;
    logic [3:0] sel_a;
    logic [3:0] sel_b;
    logic       alu_start;
    logic [2:0] alu_op;
    logic [3:0] alu_id_a;
    logic [3:0] alu_id_b;
    logic       alu_done;
    logic       busy;
    logic       op_done;
    logic       op_fail;
    logic [1:0] fail_code;
    logic [1:0] retry_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int n_sel_start = 0;
    int n_alu_start = 0;
    int n_op_fail = 0;
    int n_op_done = 0;
    int base_sel, base_alu, base_fail, base_done;

    calc_op_sequencer #(
        .ERR_HOLD_CYCLES(ERR_HOLD),
        .RETRY_MAX(2),
        .CALC_TIMEOUT(T_CALC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .op_req(op_req),
        .op_type(op_type),
        .manual_mode(manual_mode),
        .abort(abort),
        .sel_start(sel_start),
        .sel_manual(sel_manual),
        .sel_op_type(sel_op_type),
        .sel_done(sel_done),
        .sel_error(sel_error),
        .sel_a(sel_a),
        .sel_b(sel_b),
        .alu_start(alu_start),
        .alu_op(alu_op),
        .alu_id_a(alu_id_a),
        .alu_id_b(alu_id_b),
        .alu_done(alu_done),
        .busy(busy),
        .op_done(op_done),
        .op_fail(op_fail),
        .fail_code(fail_code),
        .retry_cnt(retry_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pulse counters sampled mid-cycle, used to check pulse totals per scenario.
    always @(negedge clk) begin
        if (sel_start) n_sel_start++;
        if (alu_start) n_alu_start++;
        if (op_fail)   n_op_fail++;
        if (op_done)   n_op_done++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic snap();
        base_sel  = n_sel_start;
        base_alu  = n_alu_start;
        base_fail = n_op_fail;
        base_done = n_op_done;
    endtask

    initial begin
        rst_n = 1'b0; op_req = 1'b0; op_type = 3'd0; manual_mode = 1'b0; abort = 1'b0;
        sel_done = 1'b0; sel_error = 1'b0; sel_a = 4'd0; sel_b = 4'd0; alu_done = 1'b0;

        // Reset values
        #12;
        chk("rst_outputs", {sel_start, sel_manual, sel_op_type, alu_start, alu_op, alu_id_a,
                            alu_id_b, busy, op_done, op_fail, fail_code, retry_cnt}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        steps(2);
        chk("idle_busy", busy, 1'b0);

        // Nominal add
        snap();
        op_type = 3'd1; manual_mode = 1'b0; op_req = 1'b1;
        step();
        op_req = 1'b0;
        chk("nom_busy", busy, 1'b1);
        chk("nom_sel_start", sel_start, 1'b1);
        chk("nom_sel_op", sel_op_type, 3'd1);
        chk("nom_sel_manual", sel_manual, 1'b0);
        step();
        chk("nom_sel_start_narrow", sel_start, 1'b0);
        steps(3);
        sel_done = 1'b1; sel_a = 4'd3; sel_b = 4'd7;
        step();
        sel_done = 1'b0; sel_a = 4'd0; sel_b = 4'd0;
        chk("nom_alu_start", alu_start, 1'b1);
        chk("nom_id_a", alu_id_a, 4'd3);
        chk("nom_id_b", alu_id_b, 4'd7);
        chk("nom_alu_op", alu_op, 3'd1);
        step();
        chk("nom_alu_start_narrow", alu_start, 1'b0);
        steps(18);
        alu_done = 1'b1;
        step();
        alu_done = 1'b0;
        chk("nom_op_done", op_done, 1'b1);
        chk("nom_busy_at_done", busy, 1'b1);
        step();
        chk("nom_busy_low", busy, 1'b0);
        chk("nom_op_done_narrow", op_done, 1'b0);
        chk("nom_sel_pulses", 32'(n_sel_start - base_sel), 32'd1);
        chk("nom_fail_pulses", 32'(n_op_fail - base_fail), 32'd0);

        // Retry success: error on first attempt only
        snap();
        op_type = 3'd3; manual_mode = 1'b1; op_req = 1'b1;
        step();
        op_req = 1'b0;
        step();
        sel_error = 1'b1;
        step();
        chk("rty_hold_first", sel_start, 1'b0);
        steps(ERR_HOLD - 1);
        chk("rty_hold_last", sel_start, 1'b0);
        chk("rty_cnt_before", retry_cnt, 2'd0);
        step();
        sel_error = 1'b0;
        chk("rty_clear_pulse", sel_start, 1'b1);
        chk("rty_cnt_after", retry_cnt, 2'd1);
        step();
        chk("rty_gap", sel_start, 1'b0);
        step();
        chk("rty_restart", sel_start, 1'b1);
        step();
        sel_done = 1'b1; sel_a = 4'd2; sel_b = 4'd5;
        step();
        sel_done = 1'b0;
        chk("rty_alu_start", alu_start, 1'b1);
        chk("rty_ids", {alu_id_a, alu_id_b}, 8'h25);
        chk("rty_alu_op", alu_op, 3'd3);
        chk("rty_manual", sel_manual, 1'b1);
        step();
        alu_done = 1'b1;
        step();
        alu_done = 1'b0;
        chk("rty_op_done", op_done, 1'b1);
        chk("rty_cnt_final", retry_cnt, 2'd1);
        step();
        chk("rty_busy_low", busy, 1'b0);
        chk("rty_sel_pulses", 32'(n_sel_start - base_sel), 32'd3);

        // Retry exhausted: sel_error held throughout
        snap();
        op_type = 3'd4; manual_mode = 1'b0; op_req = 1'b1; sel_error = 1'b1;
        step();
        op_req = 1'b0;
        steps(57);
        chk("exh_no_fail_yet", op_fail, 1'b0);
        step();
        chk("exh_op_fail", op_fail, 1'b1);
        chk("exh_fail_code", fail_code, 2'b01);
        chk("exh_retry_cnt", retry_cnt, 2'd2);
        sel_error = 1'b0;
        step();
        chk("exh_busy_low", busy, 1'b0);
        chk("exh_fail_code_held", fail_code, 2'b01);
        chk("exh_sel_pulses", 32'(n_sel_start - base_sel), 32'd5);
        chk("exh_alu_pulses", 32'(n_alu_start - base_alu), 32'd0);

        // Compute timeout
        snap();
        op_type = 3'd2; op_req = 1'b1;
        step();
        op_req = 1'b0;
        chk("to_fail_code_cleared", fail_code, 2'b00);
        chk("to_retry_cleared", retry_cnt, 2'd0);
        step();
        sel_done = 1'b1; sel_a = 4'd9; sel_b = 4'd1;
        step();
        sel_done = 1'b0;
        chk("to_alu_start", alu_start, 1'b1);
        chk("to_id_b_pass", alu_id_b, 4'd1);
        steps(T_CALC);
        chk("to_not_yet", op_fail, 1'b0);
        step();
        chk("to_op_fail", op_fail, 1'b1);
        chk("to_fail_code", fail_code, 2'b10);
        step();
        chk("to_busy_low", busy, 1'b0);
        chk("to_done_pulses", 32'(n_op_done - base_done), 32'd0);

        // alu_done on the expiry cycle: done wins
        snap();
        op_req = 1'b1;
        step();
        op_req = 1'b0;
        step();
        sel_done = 1'b1;
        step();
        sel_done = 1'b0;
        steps(T_CALC);
        alu_done = 1'b1;
        step();
        alu_done = 1'b0;
        chk("tob_op_done", op_done, 1'b1);
        chk("tob_op_fail", op_fail, 1'b0);
        step();
        chk("tob_fail_pulses", 32'(n_op_fail - base_fail), 32'd0);

        // Overlapping op_req ignored, then abort with sel_done: abort wins
        snap();
        op_type = 3'd1; manual_mode = 1'b0; op_req = 1'b1;
        step();
        op_req = 1'b0;
        step();
        op_req = 1'b1; op_type = 3'd4; manual_mode = 1'b1;
        step();
        op_req = 1'b0;
        chk("ovl_op_type", sel_op_type, 3'd1);
        chk("ovl_manual", sel_manual, 1'b0);
        chk("ovl_no_start", sel_start, 1'b0);
        abort = 1'b1; sel_done = 1'b1; sel_a = 4'd6; sel_b = 4'd6;
        step();
        abort = 1'b0; sel_done = 1'b0;
        chk("abt_op_fail", op_fail, 1'b1);
        chk("abt_fail_code", fail_code, 2'b11);
        chk("abt_no_alu", alu_start, 1'b0);
        step();
        chk("abt_busy_low", busy, 1'b0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abt_idle_ignored", {busy, op_fail, fail_code}, 4'b0011);
        chk("abt_alu_pulses", 32'(n_alu_start - base_alu), 32'd0);

        // sel_done with sel_error: done wins; then async reset in CALC_WAIT
        snap();
        op_type = 3'd0; op_req = 1'b1;
        step();
        op_req = 1'b0;
        step();
        sel_done = 1'b1; sel_error = 1'b1; sel_a = 4'd4; sel_b = 4'd8;
        step();
        sel_done = 1'b0; sel_error = 1'b0;
        chk("dw_alu_start", alu_start, 1'b1);
        steps(5);
        chk("ar_busy_before", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_outputs_zero", {sel_start, sel_manual, sel_op_type, alu_start, alu_op, alu_id_a,
                                alu_id_b, busy, op_done, op_fail, fail_code, retry_cnt}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        snap();
        steps(3);
        chk("ar_idle", busy, 1'b0);
        chk("ar_no_pulses", 32'(n_op_done - base_done + n_op_fail - base_fail
                                + n_sel_start - base_sel + n_alu_start - base_alu), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
